// File: rtl/dds_phase_gen.sv
// DDS phase accumulator with a tuning-word controller: immediate or linear-glide retune,
// phase sync, and a valid strobe delayed to line up with the sine lookup's registered output.
//
// state    | meaning
// ST_IDLE  | enable low; no accumulation, phase_out held
// ST_RUN   | accumulate cur_tw on every sample_tick
// ST_GLIDE | accumulate, and step cur_tw toward tgt_tw on every tick
module dds_phase_gen #(
  parameter int ADDR_WDTH  = 12,
  parameter int CNTR_WDTH  = 4,
  parameter int ACC_WDTH   = 32,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_tick,
  input  logic                           enable,
  input  logic [ACC_WDTH-1:0]            tw_data,
  input  logic                           tw_valid,
  output logic                           tw_ready,
  input  logic [ACC_WDTH-1:0]            glide_step,
  input  logic                           phase_sync,
  output logic [ADDR_WDTH+CNTR_WDTH-1:0] phase_out,
  output logic                           phase_valid,
  output logic                           value_valid,
  output logic                           busy
);

  localparam int PW = ADDR_WDTH + CNTR_WDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GLIDE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ACC_WDTH-1:0]   r_acc;
  logic [ACC_WDTH-1:0]   r_cur_tw;
  logic [ACC_WDTH-1:0]   r_tgt_tw;
  logic [ACC_WDTH-1:0]   r_step;
  logic [PW-1:0]         r_phase_out;
  logic                  r_phase_valid;
  logic [LOOKUP_LAT-1:0] r_vv_sr;

  logic                  w_accept;
  logic                  w_tick_act;
  logic                  w_direct;
  logic                  w_up;
  logic [ACC_WDTH-1:0]   w_diff;
  logic [ACC_WDTH-1:0]   w_glide_tw;
  logic [ACC_WDTH-1:0]   w_cur_nxt;
  logic [ACC_WDTH-1:0]   w_acc_nxt;

  assign w_accept   = tw_valid && (r_state != ST_GLIDE);
  assign w_tick_act = sample_tick && (r_state != ST_IDLE);
  // A new word is applied at once when no glide is requested, nothing would change, or we are idle.
  assign w_direct   = (glide_step == '0) || (tw_data == r_cur_tw) || !enable;

  // Clamp on the distance to the target so a large step can never wrap past it.
  assign w_up       = (r_tgt_tw > r_cur_tw);
  assign w_diff     = w_up ? (r_tgt_tw - r_cur_tw) : (r_cur_tw - r_tgt_tw);
  assign w_glide_tw = (r_step >= w_diff) ? r_tgt_tw :
                      (w_up ? (r_cur_tw + r_step) : (r_cur_tw - r_step));

  assign w_acc_nxt  = phase_sync ? '0 : (w_tick_act ? (r_acc + r_cur_tw) : r_acc);

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_tw;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) w_state_nxt = ST_IDLE;
      end
      ST_GLIDE: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (sample_tick) begin
          w_cur_nxt = w_glide_tw;
          if (w_glide_tw == r_tgt_tw) w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_accept) begin
      if (w_direct) w_cur_nxt = tw_data;
      else          w_state_nxt = ST_GLIDE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_acc         <= '0;
      r_cur_tw      <= '0;
      r_tgt_tw      <= '0;
      r_step        <= '0;
      r_phase_out   <= '0;
      r_phase_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_cur_tw      <= w_cur_nxt;
      r_phase_valid <= w_tick_act;
      if (w_tick_act) r_phase_out <= w_acc_nxt[ACC_WDTH-1 -: PW];
      if (w_accept) begin
        r_tgt_tw <= tw_data;
        r_step   <= glide_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vv_sr <= '0;
    end else begin
      r_vv_sr[0] <= r_phase_valid;
      for (int i = 1; i < LOOKUP_LAT; i++) r_vv_sr[i] <= r_vv_sr[i-1];
    end
  end

  assign phase_out   = r_phase_out;
  assign phase_valid = r_phase_valid;
  assign value_valid = r_vv_sr[LOOKUP_LAT-1];
  assign busy        = (r_state == ST_GLIDE);
  assign tw_ready    = (r_state != ST_GLIDE);

endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboard bench for dds_phase_gen: directed scenarios then random traffic against a behavioural model.
module tb_dds_phase_gen;
  localparam int PW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] tw_data = '0;
  logic        tw_valid = 1'b0;
  logic [31:0] glide_step = '0;
  logic        phase_sync = 1'b0;
  logic        tw_ready;
  logic [PW-1:0] phase_out;
  logic        phase_valid;
  logic        value_valid;
  logic        busy;

  dds_phase_gen #(.ADDR_WDTH(12), .CNTR_WDTH(4), .ACC_WDTH(32), .LOOKUP_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .enable(enable),
    .tw_data(tw_data), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .glide_step(glide_step), .phase_sync(phase_sync), .phase_out(phase_out),
    .phase_valid(phase_valid), .value_valid(value_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  typedef enum {M_IDLE, M_RUN, M_GLIDE} mmode_t;
  mmode_t      m_mode = M_IDLE;
  logic [31:0] m_acc = '0, m_cur = '0, m_tgt = '0, m_step = '0;
  bit          m_pv = 0, m_vv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] glide_next(input logic [31:0] cur, input logic [31:0] tgt,
                                             input logic [31:0] stp);
    longint d, mag;
    d   = $signed({32'd0, tgt}) - $signed({32'd0, cur});
    mag = (d < 0) ? -d : d;
    if (mag <= $signed({32'd0, stp})) return tgt;
    return (d > 0) ? cur + stp : cur - stp;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_acc = '0; m_cur = '0; m_tgt = '0; m_step = '0; m_pv = 0; m_vv = 0;
  endtask

  task automatic model_step(input bit tick, input bit en, input bit twv, input logic [31:0] twd,
                            input logic [31:0] gs, input bit sync);
    bit          ticking, accept;
    logic [31:0] nacc, ncur;
    mmode_t      nmode;
    ticking = tick && (m_mode != M_IDLE);
    accept  = twv && (m_mode != M_GLIDE);
    nacc    = sync ? 32'd0 : (ticking ? m_acc + m_cur : m_acc);
    ncur    = m_cur;
    nmode   = m_mode;
    if (ticking) exp_q.push_back(nacc[31:16]);
    m_vv = m_pv;
    m_pv = ticking;
    if (!en) nmode = M_IDLE;
    else if (m_mode == M_IDLE) nmode = M_RUN;
    if (m_mode == M_GLIDE && en && tick) begin
      ncur = glide_next(m_cur, m_tgt, m_step);
      if (ncur == m_tgt) nmode = M_RUN;
    end
    if (accept) begin
      m_tgt = twd;
      m_step = gs;
      if (gs == 0 || twd == m_cur || !en) ncur = twd;
      else nmode = M_GLIDE;
    end
    m_acc = nacc; m_cur = ncur; m_mode = nmode;
  endtask

  // One clock: check present outputs against the model, drive, advance the model, cross the edge.
  task automatic cyc(input bit tick, input bit en, input bit twv, input logic [31:0] twd,
                     input logic [31:0] gs, input bit sync);
    chk("busy", busy, m_mode == M_GLIDE);
    chk("tw_ready", tw_ready, m_mode != M_GLIDE);
    chk("phase_valid", phase_valid, m_pv);
    chk("value_valid", value_valid, m_vv);
    chk("cur_tw", dut.r_cur_tw, m_cur);
    sample_tick = tick; enable = en; tw_valid = twv; tw_data = twd;
    glide_step = gs; phase_sync = sync;
    model_step(tick, en, twv, twd, gs, sync);
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n, input bit en);
    repeat (n) begin
      cyc(1, en, 0, 32'h0, 32'h0, 0);
      cyc(0, en, 0, 32'h0, 32'h0, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && phase_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL phase_out: unexpected phase_valid with 0x%0h, nothing expected", phase_out);
      end else begin
        chk("phase_out", phase_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_phase_out", phase_out, 0);
    chk("rst_phase_valid", phase_valid, 0);
    chk("rst_value_valid", value_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tw_ready", tw_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // immediate load, then four ticks: 0x0100..0x0400
    cyc(0, 1, 1, 32'h0100_0000, 32'h0, 0);
    ticks(4, 1);
    // wrap-around from a synced zero
    cyc(0, 1, 1, 32'h4000_0000, 32'h0, 1);
    ticks(5, 1);
    // sync colliding with a tick at acc=0x7000_0000
    cyc(0, 1, 1, 32'h3000_0000, 32'h0, 0);
    ticks(1, 1);
    cyc(0, 1, 1, 32'h0100_0000, 32'h0, 0);
    cyc(1, 1, 0, 32'h0, 32'h0, 1);
    ticks(2, 1);
    // glide up then down with step 0x0030_0000
    cyc(0, 1, 1, 32'h0180_0000, 32'h0030_0000, 0);
    ticks(4, 1);
    cyc(0, 1, 1, 32'h0100_0000, 32'h0030_0000, 0);
    ticks(4, 1);
    // enable drop after the first glide tick
    cyc(0, 1, 1, 32'h0180_0000, 32'h0030_0000, 0);
    ticks(1, 1);
    cyc(0, 0, 0, 32'h0, 32'h0, 0);
    ticks(2, 0);
    cyc(0, 1, 0, 32'h0, 32'h0, 0);
    ticks(3, 1);

    // asynchronous reset mid-run with a non-zero accumulator
    sample_tick = 0; tw_valid = 0; phase_sync = 0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_phase_out", phase_out, 0);
    chk("async_phase_valid", phase_valid, 0);
    chk("async_value_valid", value_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_tw_ready", tw_ready, 1);
    chk("async_acc", dut.r_acc, 0);
    chk("async_pending", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    enable = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(0, 1, 1, 32'h0100_0000, 32'h0, 0);
    ticks(2, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          tk, en, tv, sy;
      logic [31:0] td, gs;
      tk = ($urandom_range(0, 1) == 1);
      en = ($urandom_range(0, 19) != 0);
      tv = ($urandom_range(0, 6) == 0);
      sy = ($urandom_range(0, 19) == 0);
      td = ($urandom_range(0, 5) == 0) ? m_cur : $urandom;
      gs = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom >> $urandom_range(2, 12));
      cyc(tk, en, tv, td, gs, sy);
    end

    repeat (4) cyc(0, 1, 0, 32'h0, 32'h0, 0);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dds_phase_gen.md
# dds_phase_gen

Phase accumulator and tuning controller that drives the sine lookup in the DDS path. It accumulates a programmable tuning word once per audio sample tick and presents the top `ADDR_WDTH+CNTR_WDTH` accumulator bits as the lookup phase word. It also supports an optional linear glide toward a new tuning word, phase synchronisation, and a valid strobe aligned to the lookup's registered output.

## Interface

Parameters:

- `ADDR_WDTH`, 12: lookup address width; matches the sine lookup.
- `CNTR_WDTH`, 4: lookup counter width; matches the sine lookup.
- `ACC_WDTH`, 32: accumulator and tuning-word width. Must be at least `ADDR_WDTH+CNTR_WDTH`.
- `LOOKUP_LAT`, 1: lookup read latency in cycles. Must be at least 1.

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  one-cycle strobe, once per output sample.
- `enable`  in  1  accumulation enable.
- `tw_data`  in  `ACC_WDTH`  target tuning word.
- `tw_valid`  in  1  `tw_data` is valid.
- `tw_ready`  out  1  block can accept a tuning word.
- `glide_step`  in  `ACC_WDTH`  tuning-word change per tick while gliding; 0 means immediate.
- `phase_sync`  in  1  zero the accumulator.
- `phase_out`  out  `ADDR_WDTH+CNTR_WDTH`  phase word to the lookup; equals `acc[ACC_WDTH-1 -: ADDR_WDTH+CNTR_WDTH]`.
- `phase_valid`  out  1  `phase_out` was updated this cycle.
- `value_valid`  out  1  lookup output `sine_value` is valid this cycle.
- `busy`  out  1  glide in progress.

## Operation

- Registers:
  - `acc` (accumulator)
  - `cur_tw` (tuning word in use)
  - `tgt_tw` (glide target)
  - `step` (glide step, latched)
- States:
  - IDLE: `enable`=0.
  - RUN
  - GLIDE
- Reset values: every register is 0; `phase_out`=0, `phase_valid`=0, `value_valid`=0, `busy`=0, `tw_ready`=1. State is IDLE.
- IDLE→RUN when `enable`=1. RUN or GLIDE→IDLE when `enable`=0.
- Leaving GLIDE through `enable`=0 abandons the glide: `cur_tw` keeps its present value and `busy` goes to 0.
- `tw_ready` = (state != GLIDE). A tuning word is accepted on `tw_valid & tw_ready`; acceptance is allowed in IDLE.
- On acceptance, `tgt_tw` is loaded from `tw_data` and `step` from `glide_step`.
  - If `glide_step`=0 or `tw_data`=`cur_tw`: `cur_tw` is loaded with `tw_data` and the state is unchanged.
  - Otherwise, if `enable`=1, the state becomes GLIDE.
  - Otherwise (`enable`=0), `cur_tw` is loaded directly (no glide in IDLE).
- On `sample_tick` in RUN or GLIDE: `acc <= acc + cur_tw`, modulo 2^`ACC_WDTH`. The addition uses the `cur_tw` value held before any same-tick glide update.
- On `sample_tick` in GLIDE, `cur_tw` moves toward `tgt_tw` by `step`, using an unsigned comparison.
  - The result is clamped to `tgt_tw`; it never overshoots.
  - The clamp check uses the difference, not a wrapped sum.
  - When the new `cur_tw` equals `tgt_tw`, the state becomes RUN.
- `sample_tick` in IDLE: no accumulation and no `phase_valid` pulse.
- `phase_sync`=1 sets `acc <= 0` in any state and has priority over a simultaneous tick.
  - If it coincides with a tick in RUN or GLIDE, `phase_out` becomes 0 and `phase_valid` pulses.
  - A glide step scheduled on that same tick still applies.
- `busy` = (state == GLIDE).

## Timing

- `sample_tick` in cycle N (RUN or GLIDE): `phase_out` holds the new `acc` bits and `phase_valid`=1 in cycle N+1.
- `value_valid` equals `phase_valid` delayed by `LOOKUP_LAT` cycles, implemented as a shift register. It is cleared by reset and is not cleared by `enable`.
- A tuning word accepted in cycle N affects ticks in cycle N+1 or later. A tick in the same cycle N uses the old `cur_tw`.
- A glide ends in RUN in cycle N+1 after the final tick; `tw_ready` rises in that same cycle.
- `phase_out` holds its value between ticks and while in IDLE.
- `rst_n` asserted mid-glide or mid-tick returns every register to its reset value immediately, asynchronously. Release is synchronous to `clk`.

## Test plan

All scenarios use the default parameters (16-bit phase word).

- **Reset:** assert `rst_n`=0 mid-run with `acc` non-zero → `phase_out`=0x0000, `phase_valid`=0, `value_valid`=0, `busy`=0, `tw_ready`=1 with no clock edge. After release, `acc` restarts from 0.
- **Immediate load:** `tw`=0x0100_0000, `glide_step`=0, `enable`=1, four ticks → `phase_out` = 0x0100, 0x0200, 0x0300, 0x0400. Each `phase_valid` is one cycle after its tick, and `value_valid` follows one cycle later.
- **Wrap-around:** `tw`=0x4000_0000, five ticks → `phase_out` = 0x4000, 0x8000, 0xC000, 0x0000, 0x4000.
- **Glide:** `cur_tw`=0x0100_0000, load target 0x0180_0000 with step 0x0030_0000 → `cur_tw` goes 0x0130_0000, 0x0160_0000, then 0x0180_0000 (clamped).
  - `busy`=1 and `tw_ready`=0 for those three ticks; both return the cycle after the third tick.
  - Repeat downward from 0x0180_0000 to 0x0100_0000 and check the mirror sequence.
- **Sync collision:** `phase_sync` and `sample_tick` in the same cycle with `acc`=0x7000_0000 → `phase_out`=0x0000 and `phase_valid`=1. The next tick with `tw`=0x0100_0000 gives 0x0100.
- **Enable drop mid-glide:** drop `enable` after the first glide tick → IDLE, `busy`=0, `cur_tw`=0x0130_0000 retained. Ticks produce no `phase_valid`; re-enabling resumes RUN at 0x0130_0000.
